fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues reads to a fixed-latency IMEM,
// tracks in-flight requests and buffers returned words for the instruction queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LATENCY = 2,
  parameter int          BUF_DEPTH    = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + IMEM_LATENCY + 1);

  logic [31:0]                        r_pc;
  logic [IMEM_LATENCY-1:0]            r_trk_vld;
  logic [IMEM_LATENCY-1:0][31:0]      r_trk_pc;
  logic [BUF_DEPTH-1:0][31:0]         r_buf_instr;
  logic [BUF_DEPTH-1:0][31:0]         r_buf_pc;
  logic [PTR_W-1:0]                   r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]                   r_count;
  logic [CNT_W-1:0]                   w_infl;
  logic                               w_req, w_push, w_pop;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < IMEM_LATENCY; i++) w_infl = w_infl + CNT_W'(r_trk_vld[i]);
  end

  // Credit check uses registered counts only, so a same-cycle pop never frees a slot early.
  assign w_req           = !rst_in && !redirect_in && ((r_count + w_infl) < CNT_W'(BUF_DEPTH));
  assign w_push          = r_trk_vld[IMEM_LATENCY-1];
  assign valid_out       = (r_count != '0) && !redirect_in;
  assign w_pop           = valid_out && ready_in;
  assign imem_req_out    = w_req;
  assign imem_addr_out   = r_pc;
  assign instruction_out = r_buf_instr[r_rd_ptr];
  assign pc_out          = r_buf_pc[r_rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pc        <= RESET_PC;
      r_trk_vld   <= '0;
      r_trk_pc    <= '0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else if (redirect_in) begin
      // Old responses still in the memory pipe are dropped because their tracker bits die here.
      r_pc      <= redirect_pc_in & 32'hFFFF_FFFC;
      r_trk_vld <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_req) r_pc <= r_pc + 32'd4;
      r_trk_vld[0] <= w_req;
      r_trk_pc[0]  <= r_pc;
      for (int i = 1; i < IMEM_LATENCY; i++) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
        r_trk_pc[i]  <= r_trk_pc[i-1];
      end
      if (w_push) begin
        r_buf_instr[r_wr_ptr] <= imem_data_in;
        r_buf_pc[r_wr_ptr]    <= r_trk_pc[IMEM_LATENCY-1];
        r_wr_ptr              <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 2-cycle IMEM model returns 0x1000_0000 + (addr>>2).
module tb_fetch_unit;
  logic        clk_in = 1'b0;
  logic        rst_in, imem_req_out, redirect_in, ready_in, valid_out;
  logic [31:0] imem_addr_out, imem_data_in, redirect_pc_in, instruction_out, pc_out;
  logic [31:0] a_d1, a_d2, exp_pc;
  int          n_chk = 0, n_fail = 0;

  fetch_unit dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out), .imem_data_in(imem_data_in),
    .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .ready_in(ready_in), .valid_out(valid_out),
    .instruction_out(instruction_out), .pc_out(pc_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    a_d1 <= imem_addr_out;
    a_d2 <= a_d1;
  end
  assign imem_data_in = 32'h1000_0000 + (a_d2 >> 2);

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(posedge clk_in);
    #1;
    rst_in = rst; ready_in = rdy; redirect_in = rdr; redirect_pc_in = rpc;
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next consecutive PC.
  task automatic sb();
    if (valid_out && ready_in) begin
      chk("sb_pc", pc_out, exp_pc);
      chk("sb_instr", instruction_out, word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    rst_in = 1'b1; ready_in = 1'b1; redirect_in = 1'b0; redirect_pc_in = '0; exp_pc = '0;
    repeat (3) step(1, 1, 0, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_req", imem_req_out, 0);
    chk("rst_addr", imem_addr_out, 32'h0);
    chk("rst_instr", instruction_out, 0);
    chk("rst_pc", pc_out, 0);

    // Cycle 0..2: requests start immediately, nothing valid yet
    step(0, 1, 0, 0);
    chk("c0_req", imem_req_out, 1);
    chk("c0_addr", imem_addr_out, 32'h0);
    chk("c0_valid", valid_out, 0);
    step(0, 1, 0, 0);
    chk("c1_addr", imem_addr_out, 32'h4);
    chk("c1_valid", valid_out, 0);
    step(0, 1, 0, 0);
    chk("c2_valid", valid_out, 0);
    exp_pc = 32'h0;
    for (int c = 3; c <= 22; c++) begin
      step(0, 1, 0, 0);
      chk("stream_valid", valid_out, 1);
      sb();
    end

    // Backpressure: one more request, then stall with head held at 0x50
    step(0, 0, 0, 0);
    chk("bp_last_req", imem_req_out, 1);
    chk("bp_last_addr", imem_addr_out, 32'd92);
    chk("bp_head", pc_out, 32'd80);
    for (int c = 24; c <= 32; c++) begin
      step(0, 0, 0, 0);
      chk("bp_noreq", imem_req_out, 0);
      chk("bp_valid", valid_out, 1);
      chk("bp_head", pc_out, 32'd80);
    end
    for (int c = 33; c <= 52; c++) begin
      step(0, 1, 0, 0);
      chk("resume_valid", valid_out, 1);
      sb();
    end

    // Redirect with 2 buffered and 2 in flight
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h100);
    chk("rd_valid_forced", valid_out, 0);
    chk("rd_noreq", imem_req_out, 0);
    step(0, 1, 0, 0);
    chk("rd_req", imem_req_out, 1);
    chk("rd_addr", imem_addr_out, 32'h100);
    chk("rd_t1_valid", valid_out, 0);
    step(0, 1, 0, 0);
    chk("rd_t2_valid", valid_out, 0);
    step(0, 1, 0, 0);
    chk("rd_t3_valid", valid_out, 0);
    exp_pc = 32'h100;
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 0, 0);
      chk("rd_stream_valid", valid_out, 1);
      sb();
    end

    // Misaligned redirect target
    step(0, 1, 1, 32'h103);
    chk("mis_valid", valid_out, 0);
    step(0, 1, 0, 0);
    chk("mis_addr", imem_addr_out, 32'h100);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("mis_t3_valid", valid_out, 0);
    exp_pc = 32'h100;
    for (int c = 0; c < 2; c++) begin
      step(0, 1, 0, 0);
      chk("mis_stream_valid", valid_out, 1);
      sb();
    end

    // Back-to-back redirects: last wins
    step(0, 1, 1, 32'h200);
    step(0, 1, 1, 32'h300);
    chk("b2b_valid", valid_out, 0);
    step(0, 1, 0, 0);
    chk("b2b_addr", imem_addr_out, 32'h300);
    for (int c = 0; c < 2; c++) begin
      step(0, 1, 0, 0);
      chk("b2b_gap_valid", valid_out, 0);
    end
    exp_pc = 32'h300;
    for (int c = 0; c < 4; c++) begin
      step(0, 1, 0, 0);
      chk("b2b_stream_valid", valid_out, 1);
      sb();
    end

    // Reset overrides a simultaneous redirect
    step(1, 1, 1, 32'h500);
    chk("mrst_req", imem_req_out, 0);
    chk("mrst_valid", valid_out, 0);
    step(1, 1, 0, 0);
    chk("mrst2_valid", valid_out, 0);
    chk("mrst2_req", imem_req_out, 0);
    chk("mrst2_addr", imem_addr_out, 32'h0);
    chk("mrst2_instr", instruction_out, 0);
    chk("mrst2_pc", pc_out, 0);
    step(0, 1, 0, 0);
    chk("mrst_c0_req", imem_req_out, 1);
    chk("mrst_c0_addr", imem_addr_out, 32'h0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("mrst_c2_valid", valid_out, 0);
    exp_pc = 32'h0;
    for (int c = 0; c < 4; c++) begin
      step(0, 1, 0, 0);
      chk("mrst_stream_valid", valid_out, 1);
      sb();
    end

    // PC wraps past the top of the address space
    step(0, 1, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wrap_addr", imem_addr_out, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("wrap_t3_valid", valid_out, 0);
    exp_pc = 32'hFFFF_FFFC;
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 0, 0);
      chk("wrap_stream_valid", valid_out, 1);
      sb();
    end
    chk("wrap_final_exp", exp_pc, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
